// File: rtl/mul_div_seq_pkg.sv
// Shared constants and types for the sequential 8-bit multiply/divide unit.
package mul_div_seq_pkg;

  localparam int WIDTH = 8;
  localparam int STEPS = WIDTH;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam logic [WIDTH-1:0] DIV0_QUOT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_div_seq_if.sv
// Host-side bus of the multiply/divide unit, plus the FSM state for observation.
interface mul_div_seq_if;
  import mul_div_seq_pkg::*;

  // start/op/a/b are taken in the cycle the unit is idle (busy=0); a start while
  // busy, including the done cycle, is dropped. done pulses once per accepted start.
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             div_by_zero;
  state_t           state;

  modport master (
    output start, op, a, b,
    input  busy, done, result_hi, result_lo, div_by_zero, state
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_hi, result_lo, div_by_zero, state
  );

endinterface

// File: rtl/mul_div_seq_sumator_scazator.sv
// 8-bit ripple add/subtract unit: sub=0 gives in_1+in_2, sub=1 gives in_1-in_2 (cout=1 means no borrow).
module SumatorScazator (
  input  logic [7:0] in_1,
  input  logic [7:0] in_2,
  input  logic       sub,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] carry;
  logic [7:0] in_2_x;

  always_comb begin
    carry    = '0;
    sum      = '0;
    in_2_x   = in_2 ^ {8{sub}};
    carry[0] = sub;
    for (int i = 0; i < 8; i++) begin
      sum[i]     = in_1[i] ^ in_2_x[i] ^ carry[i];
      carry[i+1] = (in_1[i] & in_2_x[i]) | (carry[i] & (in_1[i] ^ in_2_x[i]));
    end
    cout = carry[8];
  end

endmodule

// File: rtl/mul_div_seq.sv
// Multi-cycle unsigned 8x8 multiply (shift-and-add) / 8/8 divide (restoring),
// one add/subtract per clock through a single shared adder.
module mul_div_seq
  import mul_div_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst_b,
  mul_div_seq_if.slave bus
);

  state_t           state, state_nxt;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q, m;
  logic [3:0]       cnt;
  logic             op_r;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             dz;

  logic             accept, div0, last_step;
  logic [WIDTH:0]   acc_sh, mul_acc, acc_step;
  logic [WIDTH-1:0] q_sh, q_step, add_in_1, add_sum;
  logic             add_cout, ok;

  assign accept    = (state == IDLE) && bus.start;
  assign div0      = (bus.op == OP_DIV) && (bus.b == '0);
  assign last_step = (cnt == 4'(STEPS - 1));

  // Divide shifts {A,Q} left before subtracting, so the adder sees the shifted A.
  assign acc_sh   = {acc[WIDTH-1:0], q[WIDTH-1]};
  assign q_sh     = {q[WIDTH-2:0], 1'b0};
  assign add_in_1 = (op_r == OP_DIV) ? acc_sh[WIDTH-1:0] : acc[WIDTH-1:0];

  SumatorScazator u_addsub (
    .in_1 (add_in_1),
    .in_2 (m),
    .sub  (op_r),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    mul_acc  = acc;
    acc_step = acc;
    q_step   = q;
    ok       = 1'b0;
    if (op_r == OP_MUL) begin
      mul_acc  = q[0] ? {add_cout, add_sum} : acc;
      acc_step = {1'b0, mul_acc[WIDTH:1]};
      q_step   = {mul_acc[0], q[WIDTH-1:1]};
    end else begin
      ok       = acc_sh[WIDTH] | add_cout;
      acc_step = ok ? {1'b0, add_sum} : acc_sh;
      q_step   = {q_sh[WIDTH-1:1], ok};
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = div0 ? DONE : RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (state != IDLE);
    bus.done        = (state == DONE);
    bus.state       = state;
    bus.result_hi   = res_hi;
    bus.result_lo   = res_lo;
    bus.div_by_zero = dz;
  end

  // Results only change on the way into DONE, so they hold across later starts.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      acc    <= '0;
      q      <= '0;
      m      <= '0;
      cnt    <= '0;
      op_r   <= OP_MUL;
      res_hi <= '0;
      res_lo <= '0;
      dz     <= 1'b0;
    end else if (accept) begin
      acc  <= '0;
      q    <= bus.a;
      m    <= bus.b;
      cnt  <= '0;
      op_r <= bus.op;
      dz   <= div0;
      if (div0) begin
        res_hi <= bus.a;
        res_lo <= DIV0_QUOT;
      end
    end else if (state == RUN) begin
      acc <= acc_step;
      q   <= q_step;
      cnt <= cnt + 4'd1;
      if (last_step) begin
        res_hi <= acc_step[WIDTH-1:0];
        res_lo <= q_step;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_seq.sv
// Randomized and directed bench for mul_div_seq against an arithmetic reference model.
module tb_mul_div_seq;
  import mul_div_seq_pkg::*;

  logic clk;
  logic rst_b;
  int   total;
  int   bad;
  logic [16:0] exp_q[$];
  logic [16:0] prev_res;

  mul_div_seq_if bus ();

  mul_div_seq dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: {div_by_zero, result_hi, result_lo}
  function automatic logic [16:0] model(input logic op_i, input logic [7:0] a_i, input logic [7:0] b_i);
    logic [15:0] p;
    logic [7:0]  quo, rem;
    if (op_i == OP_MUL) begin
      p = a_i * b_i;
      return {1'b0, p};
    end
    if (b_i == 8'd0) return {1'b1, a_i, 8'hFF};
    quo = a_i / b_i;
    rem = a_i % b_i;
    return {1'b0, rem, quo};
  endfunction

  task automatic check_result(input string tag);
    logic [16:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_hi"}, bus.result_hi, e[15:8]);
    check({tag, "_lo"}, bus.result_lo, e[7:0]);
    check({tag, "_dz"}, bus.div_by_zero, e[16]);
    prev_res = e;
  endtask

  // Drives start in the current cycle; caller must be just after a negedge with the unit idle.
  task automatic run_op(input string tag, input logic op_i, input logic [7:0] a_i, input logic [7:0] b_i);
    int   edges;
    int   busy_cycles;
    logic is_div0;
    is_div0 = (op_i == OP_DIV) && (b_i == 8'd0);
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    exp_q.push_back(model(op_i, a_i, b_i));
    edges = 0;
    busy_cycles = 0;
    while (edges < 40) begin
      @(negedge clk);
      edges++;
      if (edges == 1) begin
        bus.start = 1'b0;
        if (!is_div0) begin
          check({tag, "_dzclr"}, bus.div_by_zero, 0);
          check({tag, "_hold"}, {bus.result_hi, bus.result_lo}, prev_res[15:0]);
        end
      end
      if (bus.busy) busy_cycles++;
      if (bus.done) break;
    end
    if (!bus.done) check({tag, "_timeout"}, 0, 1);
    check({tag, "_lat"}, edges, is_div0 ? 1 : 9);
    check({tag, "_busy"}, busy_cycles, is_div0 ? 1 : 9);
    check_result(tag);
    @(negedge clk);
    check({tag, "_idle"}, {bus.busy, bus.done}, 0);
  endtask

  initial begin
    int i;
    total = 0;
    bad = 0;
    prev_res = '0;
    rst_b = 1'b0;
    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_res", {bus.result_hi, bus.result_lo}, 0);
    check("rst_dz", bus.div_by_zero, 0);
    check("rst_state", bus.state, IDLE);
    rst_b = 1'b1;
    @(negedge clk);

    // directed cases
    run_op("mul13x11", OP_MUL, 8'd13, 8'd11);
    run_op("mul255x255", OP_MUL, 8'hFF, 8'hFF);
    run_op("mul0x200", OP_MUL, 8'd0, 8'd200);
    run_op("div200_7", OP_DIV, 8'd200, 8'd7);
    run_op("div255_1", OP_DIV, 8'd255, 8'd1);
    run_op("div5_9", OP_DIV, 8'd5, 8'd9);
    run_op("div77_0", OP_DIV, 8'd77, 8'd0);
    run_op("after_div0", OP_MUL, 8'd6, 8'd7);

    // starts during RUN and during the done cycle are ignored
    bus.start = 1'b1;
    bus.op = OP_MUL;
    bus.a = 8'd3;
    bus.b = 8'd4;
    exp_q.push_back(model(OP_MUL, 8'd3, 8'd4));
    i = 0;
    while (i < 20) begin
      @(negedge clk);
      i++;
      bus.start = 1'b0;
      if (i == 3 || i == 9) begin
        bus.start = 1'b1;
        bus.op = 1'($urandom_range(0, 1));
        bus.a = 8'($urandom_range(50, 255));
        bus.b = 8'($urandom_range(0, 255));
      end
      if (bus.done) break;
    end
    check("hs_done_cycle", i, 9);
    check_result("hs");
    @(negedge clk);
    bus.start = 1'b0;
    check("hs_ignored", bus.busy, 0);
    check("hs_res_held", {bus.result_hi, bus.result_lo}, 16'h000C);
    run_op("hs_b2b", OP_DIV, 8'd100, 8'd10);

    // asynchronous reset in the middle of RUN
    bus.start = 1'b1;
    bus.op = OP_MUL;
    bus.a = 8'd99;
    bus.b = 8'd77;
    repeat (5) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #2;
    rst_b = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_res", {bus.result_hi, bus.result_lo}, 0);
    check("arst_dz", bus.div_by_zero, 0);
    @(negedge clk);
    rst_b = 1'b1;
    prev_res = '0;
    begin
      int seen;
      seen = 0;
      repeat (12) begin
        @(negedge clk);
        if (bus.done || bus.busy) seen++;
      end
      check("arst_no_done", seen, 0);
    end
    run_op("post_rst", OP_MUL, 8'd21, 8'd12);

    // random mix, with occasional zero divisors
    for (int k = 0; k < 24; k++) begin
      logic       op_r;
      logic [7:0] a_r, b_r;
      op_r = 1'($urandom_range(0, 1));
      a_r  = 8'($urandom_range(0, 255));
      b_r  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      run_op("rnd", op_r, a_r, b_r);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_div_seq.md
Name: mul_div_seq

Overview:
- Multi-cycle 8-bit unsigned multiply/divide sequencer built around one instance of the team's 8-bit ripple add/subtract unit (SumatorScazator).
- Multiply uses shift-and-add; divide uses restoring shift-and-subtract.
- One add/subtract operation per clock. The host sees a start/busy/done handshake.
- Sits between the ALU operand registers and the result mux, as the multi-cycle MUL/DIV path.

Parameters:
- WIDTH, 8: operand width. Fixed to the add/subtract unit width; any other value is unsupported.
- STEPS, 8: iteration count, equal to WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_b  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  1  0 = multiply, 1 = divide; sampled with start.
- a  input  8  multiplicand / dividend; sampled with start.
- b  input  8  multiplier / divisor; sampled with start.
- busy  output  1  high while an operation is in progress (RUN or DONE).
- done  output  1  single-cycle completion pulse.
- result_hi  output  8  MUL: product[15:8]; DIV: remainder.
- result_lo  output  8  MUL: product[7:0]; DIV: quotient.
- div_by_zero  output  1  set at completion when op=1 and b=0.

Behaviour:
- Reset (async, rst_b=0):
  - state=IDLE; busy, done, div_by_zero = 0; result_hi, result_lo = 0.
  - All internal registers (A[8:0], Q, M, cnt) = 0.
  - Reset mid-operation aborts it; no done pulse follows.
- Internal registers: A is 9 bits (A[8] is the extension/carry bit); Q is 8 bits; M is 8 bits; cnt is 4 bits.
- State IDLE:
  - start=1 → latch M=b, Q=a, A=0, cnt=0, op.
  - If op=1 and b=0 → go to DONE.
  - Otherwise → go to RUN.
  - start=0 → stay in IDLE.
- State RUN, one step per cycle, cnt increments each step; after step 8 (cnt=7 at the edge) → DONE.
  - MUL step, adder sub=0, inputs A[7:0] and M:
    - If Q[0]=1: {A[8],A[7:0]} = {Cout,sum}, else A is unchanged.
    - Then shift right {A[8],A[7:0],Q}, with 0 into bit 16.
  - DIV step:
    - First shift left {A[7:0],Q} into {A[8:0],Q}, Q[0]=0.
    - Then drive the adder with sub=1, inputs A[7:0] and M.
    - ok = A[8] | Cout.
    - If ok: A = {1'b0,sum} and Q[0]=1. Otherwise A is unchanged and Q[0]=0.
- State DONE (exactly one cycle):
  - done=1.
  - MUL: result_hi=A[7:0], result_lo=Q.
  - DIV: result_hi=A[7:0], result_lo=Q.
  - Divide-by-zero: result_hi=a (latched), result_lo=8'hFF, div_by_zero=1.
  - Next state is IDLE.
- Output registers:
  - Results and div_by_zero are registered and hold until the next accepted start.
  - On the next accepted start, div_by_zero clears and results hold until DONE.
- busy:
  - 1 in RUN and DONE; 0 in IDLE.
  - Goes high on the edge after start is accepted.
- Latency:
  - Normal case: start accepted at edge k → done high after edge k+9 (8 RUN cycles plus 1 DONE cycle).
  - Divide-by-zero: done high after edge k+1.
- Handshake:
  - start while busy=1 is ignored; operands are not relatched.
  - start in the same cycle as done is ignored. Back-to-back operations require start in IDLE, i.e. the cycle after done at the earliest.
- The adder is combinational inside the step. There is no extra pipeline stage.

Decomposition:
- Shared package/header holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - OP_MUL=1'b0, OP_DIV=1'b1;
  - WIDTH=8;
  - DIV0_QUOT=8'hFF.
- One sub-module: the existing SumatorScazator, instantiated once.
  - Its sub input is driven by op (0 in MUL, 1 in DIV).
  - Its in_1 input is A[7:0]; its in_2 input is M.
- FSM, counter and shift registers stay in mul_div_seq.

Test Plan:
- MUL 13×11: op=0, a=8'd13, b=8'd11, start pulse → done after 9 edges; result_hi=8'h00, result_lo=8'h8F, div_by_zero=0; busy high for exactly 9 cycles.
- MUL 255×255: a=8'hFF, b=8'hFF → result_hi=8'hFE, result_lo=8'h01. Also check 0×200 → 16'h0000.
- DIV 200/7: op=1, a=8'd200, b=8'd7 → result_lo=8'd28, result_hi=8'd4. Also check 255/1 → 8'hFF r 0, and 5/9 → 0 r 5.
- DIV by zero: op=1, a=8'd77, b=0 → done one edge after start; div_by_zero=1, result_lo=8'hFF, result_hi=8'd77. The next valid op clears div_by_zero at start.
- Handshake: start a MUL 3×4, then pulse start with different operands at cycles 3 and 9 (done cycle) → ignored, result=16'h000C. A start the cycle after done is accepted.
- Reset mid-operation: assert rst_b=0 during RUN at cnt=4 → all outputs 0 immediately (async); no done pulse; next start runs normally.
